// File: rtl/blkmm_pkg.sv
// blkmm_pkg: shared block-matmul parameters, FSM state enum and Tn x Tn block/vector types
package blkmm_pkg;
  localparam int Tn = 4;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int N  = 16;
  localparam int KW = $clog2(Tn);
  localparam int IW = $clog2(Tn*Tn);
  typedef enum logic [1:0] {IDLE, MAC, WRITE} state_t;
  typedef logic [DW-1:0] blk_t [0:Tn-1][0:Tn-1];
  typedef logic [DW-1:0] vec_t [0:Tn-1];
endpackage

// File: rtl/block_mac_array.sv
// block_mac_array: Tn x Tn MAC grid; acc[i][j] += a_col[i]*b_row[j] when en, clr drops the old acc (clk, rst, en, clr, a_col, b_row -> acc)
module block_mac_array
  import blkmm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  vec_t a_col,
  input  vec_t b_row,
  output blk_t acc
);
  always_ff @(posedge clk)
    for (int i = 0; i < Tn; i++)
      for (int j = 0; j < Tn; j++)
        if (rst) acc[i][j] <= '0;
        else if (en) acc[i][j] <= (clr ? '0 : acc[i][j]) + a_col[i] * b_row[j];
endmodule

// File: rtl/block_mac_acc.sv
// block_mac_acc: C_blk += A_blk*B_blk per k-step, row-major C write-back on flush (start/clear/flush, block_row/col, block_mat_a/b -> addrc, doutc, wec, busy, done)
module block_mac_acc
  import blkmm_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          clear,
  input  logic          flush,
  input  logic [7:0]    block_row,
  input  logic [7:0]    block_col,
  input  blk_t          block_mat_a,
  input  blk_t          block_mat_b,
  output logic [AW-1:0] addrc,
  output logic [DW-1:0] doutc,
  output logic          wec,
  output logic          busy,
  output logic          done
);
  state_t state, state_n;
  blk_t a_r, b_r, acc;
  vec_t a_col, b_row;
  logic [7:0] row_r, col_r;
  logic clr_r, fl_r;
  logic [KW-1:0] kk, wi, wj;
  logic [IW-1:0] idx;
  logic [AW-1:0] addr_now, addr_q;
  logic [DW-1:0] dout_q;
  assign wi = idx[IW-1:KW];
  assign wj = idx[KW-1:0];
  assign wec = state == WRITE;
  assign busy = state != IDLE;
  assign addr_now = (AW'(row_r) + AW'(wi)) * AW'(N) + AW'(col_r) + AW'(wj);
  // outputs hold the last written beat once the write burst ends
  assign addrc = wec ? addr_now : addr_q;
  assign doutc = wec ? acc[wi][wj] : dout_q;
  always_comb
    state_n = state == IDLE ? (start ? MAC : IDLE)
            : state == MAC ? (kk == KW'(Tn-1) ? (fl_r ? WRITE : IDLE) : MAC)
            : (idx == IW'(Tn*Tn-1) ? IDLE : WRITE);
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_ff @(posedge clk)
    if (rst) begin
      kk <= '0;
      idx <= '0;
      done <= 1'b0;
      addr_q <= '0;
      dout_q <= '0;
    end else begin
      kk <= state == MAC ? kk + 1'b1 : '0;
      idx <= state == WRITE ? idx + 1'b1 : '0;
      done <= (state == MAC && kk == KW'(Tn-1) && !fl_r) || (state == WRITE && idx == IW'(Tn*Tn-1));
      if (wec) begin
        addr_q <= addr_now;
        dout_q <= acc[wi][wj];
      end
      if (state == IDLE && start) begin
        a_r <= block_mat_a;
        b_r <= block_mat_b;
        row_r <= block_row;
        col_r <= block_col;
        clr_r <= clear;
        fl_r <= flush;
      end
    end
  always_comb
    for (int i = 0; i < Tn; i++) begin
      a_col[i] = a_r[i][kk];
      b_row[i] = b_r[kk][i];
    end
  block_mac_array u_arr (
    .clk  (clk),
    .rst  (rst),
    .en   (state == MAC),
    .clr  (clr_r && kk == '0),
    .a_col(a_col),
    .b_row(b_row),
    .acc  (acc)
  );
endmodule
